// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the word-indexed PC, drives instruction memory,
// and captures the returned word into the IF/ID pipeline register.
module if_fetch_unit #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 100,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_out,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] DEPTH    = XLEN'(MEM_DEPTH);
    localparam logic [XLEN-1:0] LAST_PC  = XLEN'(MEM_DEPTH - 1);
    localparam logic [XLEN-1:0] START_PC = XLEN'(RESET_PC);

    state_t          state, state_next;
    logic [XLEN-1:0] pc_next;
    logic            valid_next;
    logic [XLEN-1:0] if_id_pc_next;
    logic [XLEN-1:0] if_id_instr_next;
    logic            fault_next;
    logic [XLEN-1:0] count_next;
    logic            target_ok;
    logic [XLEN-1:0] pc_seq;

    // Unsigned compare: any target at or beyond the memory depth is a fault.
    assign target_ok = (redirect_pc < DEPTH);
    assign pc_seq    = (pc_out == LAST_PC) ? '0 : pc_out + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a hold value first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_next       = state;
        pc_next          = pc_out;
        valid_next       = if_id_valid;
        if_id_pc_next    = if_id_pc;
        if_id_instr_next = if_id_instr;
        fault_next       = fetch_fault;
        count_next       = fetch_count;

        case (state)
            BOOT: begin
                // One settling cycle for the memory; stall and redirect ignored.
                state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    if (target_ok) begin
                        pc_next = redirect_pc;
                    end else begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_pc_next    = pc_out;
                    if_id_instr_next = instr_in;
                    valid_next       = 1'b1;
                    count_next       = fetch_count + 1'b1;
                    pc_next          = pc_seq;
                end
            end
            FAULT: begin
                valid_next = 1'b0;
                fault_next = 1'b1;
            end
            default: begin
                state_next = BOOT;
                valid_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc_out      <= START_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc_out      <= pc_next;
            if_id_valid <= valid_next;
            if_id_pc    <= if_id_pc_next;
            if_id_instr <= if_id_instr_next;
            fetch_fault <= fault_next;
            fetch_count <= count_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a behavioural
// instruction memory answering combinationally for pc_out.
module tb_if_fetch_unit;

    localparam int XLEN = 32;
    localparam int DEPTH = 100;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc_out;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_instr;
    logic            fetch_fault;
    logic [XLEN-1:0] fetch_count;

    logic [XLEN-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    if_fetch_unit #(.XLEN(XLEN), .MEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_in    (instr_in),
        .pc_out      (pc_out),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign instr_in = (pc_out < DEPTH) ? mem[pc_out] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input logic [XLEN-1:0] pc,
                                input logic v, input logic [XLEN-1:0] ipc,
                                input logic [XLEN-1:0] cnt, input logic flt);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
        check({tag, ".if_id_pc"}, if_id_pc, ipc);
        check({tag, ".count"}, fetch_count, cnt);
        check({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, flt});
    endtask

    task automatic do_boot(input string tag);
        @(negedge clk);
        reset = 1'b0;
        step();
        expect_state({tag, ".e1"}, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        expect_state({tag, ".e2"}, 32'd1, 1'b1, 32'd0, 32'd1, 1'b0);
        check({tag, ".e2.instr"}, if_id_instr, 32'h09);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h09;
        mem[1] = 32'h0;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #3;
        expect_state("reset", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("reset.instr", if_id_instr, 32'd0);
        @(negedge clk);

        // Boot; BOOT edge ignores a redirect request.
        reset = 1'b0;
        redirect = 1'b1; redirect_pc = 32'd50; stall = 1'b1;
        step();
        expect_state("boot.e1", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step();
        expect_state("boot.e2", 32'd1, 1'b1, 32'd0, 32'd1, 1'b0);
        check("boot.e2.instr", if_id_instr, 32'h09);
        step();
        expect_state("boot.e3", 32'd2, 1'b1, 32'd1, 32'd2, 1'b0);
        check("boot.e3.instr", if_id_instr, 32'h0);

        // Wrap-around at MEM_DEPTH.
        redirect = 1'b1; redirect_pc = 32'd98;
        step();
        expect_state("wrap.redir", 32'd98, 1'b0, 32'd1, 32'd2, 1'b0);
        redirect = 1'b0;
        step();
        expect_state("wrap.a1", 32'd99, 1'b1, 32'd98, 32'd3, 1'b0);
        check("wrap.a1.instr", if_id_instr, 32'h1000_0062);
        step();
        expect_state("wrap.a2", 32'd0, 1'b1, 32'd99, 32'd4, 1'b0);
        step();
        expect_state("wrap.a3", 32'd1, 1'b1, 32'd0, 32'd5, 1'b0);
        check("wrap.a3.instr", if_id_instr, 32'h09);

        // Redirect wins over stall.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd40;
        step();
        expect_state("rds.redir", 32'd40, 1'b0, 32'd0, 32'd5, 1'b0);
        stall = 1'b0; redirect = 1'b0;
        step();
        expect_state("rds.next", 32'd41, 1'b1, 32'd40, 32'd6, 1'b0);
        check("rds.next.instr", if_id_instr, 32'h1000_0028);

        // Stall hold at pc=7, then release without a bubble.
        redirect = 1'b1; redirect_pc = 32'd6;
        step();
        redirect = 1'b0;
        step();
        expect_state("stall.pre", 32'd7, 1'b1, 32'd6, 32'd7, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_state($sformatf("stall.h%0d", i), 32'd7, 1'b1, 32'd6, 32'd7, 1'b0);
            check($sformatf("stall.h%0d.instr", i), if_id_instr, 32'h1000_0006);
        end
        stall = 1'b0;
        step();
        expect_state("stall.rel", 32'd8, 1'b1, 32'd7, 32'd8, 1'b0);
        check("stall.rel.instr", if_id_instr, 32'h1000_0007);

        // Asynchronous reset between edges at pc=25.
        redirect = 1'b1; redirect_pc = 32'd24;
        step();
        redirect = 1'b0;
        step();
        expect_state("arst.pre", 32'd25, 1'b1, 32'd24, 32'd9, 1'b0);
        #2 reset = 1'b1;
        #1;
        expect_state("arst.now", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("arst.instr", if_id_instr, 32'd0);
        do_boot("arst.boot");

        // Out-of-range redirect to MEM_DEPTH.
        redirect = 1'b1; redirect_pc = 32'd100;
        step();
        expect_state("f100.hit", 32'd1, 1'b0, 32'd0, 32'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            redirect = i[1];
            redirect_pc = 32'd5;
            step();
            expect_state($sformatf("f100.hold%0d", i), 32'd1, 1'b0, 32'd0, 32'd1, 1'b1);
        end
        stall = 1'b0; redirect = 1'b0;
        reset = 1'b1;
        #1;
        expect_state("f100.rst", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        do_boot("f100.boot");

        // Out-of-range redirect to the all-ones address.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        expect_state("fmax.hit", 32'd1, 1'b0, 32'd0, 32'd1, 1'b1);
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = ~i[0];
            step();
            expect_state($sformatf("fmax.hold%0d", i), 32'd1, 1'b0, 32'd0, 32'd1, 1'b1);
        end
        stall = 1'b0;
        reset = 1'b1;
        #1;
        expect_state("fmax.rst", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        do_boot("fmax.boot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
